// File: rtl/swm_sequencer.sv
// -----------------------------------------------------------------------------
// swm_sequencer
//
// Store-multiple engine. On an accepted start it latches a register-select
// mask and a base byte address, then walks the mask from bit 0 upward. For
// each selected register it reads the register file (READ) and issues one
// handshaked word write to data memory (WRITE). Consecutive stored words go
// to consecutive STRIDE-spaced addresses, independent of register number.
// When the mask is exhausted it pulses done_o for one cycle (DONE) and
// returns to IDLE.
//
// Handshake: a memory write transfers on any rising edge where
// mem_req_o=1 and mem_ready_i=1. While mem_req_o=1 and mem_ready_i=0 the
// address and data are held stable and mem_req_o stays high.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      store-multiple valid, sampled only in IDLE
//   addrcode_i   register-select mask (bit k selects register k)
//   base_i       base byte address
//   rf_data_i    register file read data for rf_addr_o (same cycle)
//   rf_addr_o    register file read index
//   mem_req_o    memory write request
//   mem_addr_o   memory write byte address
//   mem_wdata_o  memory write data
//   mem_ready_i  memory accepts the write when high with mem_req_o
//   stall_o      holds the upstream pipeline
//   busy_o       high in every state except IDLE
//   done_o       one-cycle completion pulse
//
// The FSM state is held in state_q (type state_t) for observation.
// -----------------------------------------------------------------------------
module swm_sequencer #(
    parameter int MASK_W = 21,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRIDE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [MASK_W-1:0] addrcode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [4:0]        rf_addr_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [MASK_W-1:0] mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        idx_q;

    logic [4:0]        enc_idx;
    logic [MASK_W-1:0] mask_clr;
    logic              accept_start;
    logic              accept_write;

    // Lowest set bit wins: scan from the top so lower indices overwrite.
    always_comb begin
        enc_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                enc_idx = 5'(i);
            end
        end
    end

    // Mask with the register just written removed.
    assign mask_clr = mask_q & ~(MASK_W'(1) << idx_q);

    assign accept_start = (state_q == IDLE) && start_i;
    assign accept_write = (state_q == WRITE) && mem_ready_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs.
    always_comb begin
        state_d     = state_q;
        rf_addr_o   = '0;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        stall_o     = 1'b0;
        busy_o      = (state_q != IDLE);
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                stall_o = start_i;
                if (start_i) begin
                    state_d = (addrcode_i != '0) ? READ : DONE;
                end
            end
            READ: begin
                stall_o   = 1'b1;
                rf_addr_o = enc_idx;
                state_d   = WRITE;
            end
            WRITE: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                if (mem_ready_i) begin
                    state_d = (mask_clr != '0) ? READ : DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are forced low for as long as reset is held, including
        // stall_o, which would otherwise follow start_i in IDLE.
        if (rst_i) begin
            rf_addr_o   = '0;
            mem_req_o   = 1'b0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
            stall_o     = 1'b0;
            busy_o      = 1'b0;
            done_o      = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else begin
            if (accept_start) begin
                mask_q <= addrcode_i;
                addr_q <= base_i;
            end
            if (state_q == READ) begin
                wdata_q <= rf_data_i;
                idx_q   <= enc_idx;
            end
            if (accept_write) begin
                mask_q <= mask_clr;
                addr_q <= addr_q + ADDR_W'(STRIDE);
            end
        end
    end

endmodule

// File: tb/tb_swm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_swm_sequencer
//
// Directed bench for swm_sequencer. A reference model expands each mask into
// the ordered list of (address, data) writes it must produce; a negedge
// monitor pops that list on every accepted write and checks bus hold during
// backpressure. Per-operation cycle counts and a few literal write values
// are checked in the main sequence.
// -----------------------------------------------------------------------------
module tb_swm_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [20:0] addrcode_i;
    logic [31:0] base_i;
    logic [31:0] rf_data_i;
    logic [4:0]  rf_addr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;

    swm_sequencer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .addrcode_i  (addrcode_i),
        .base_i      (base_i),
        .rf_data_i   (rf_data_i),
        .rf_addr_o   (rf_addr_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .stall_o     (stall_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- register file model ----------------
    logic [31:0] rf [0:31];
    assign rf_data_i = rf[rf_addr_o];

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    int          done_total = 0;
    logic [63:0] exp_q[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The k-th selected register (ascending) goes to base + 4*k.
    task automatic build_model(input logic [20:0] m, input logic [31:0] b);
        int n;
        n = 0;
        for (int k = 0; k < 21; k++) begin
            if (m[k]) begin
                exp_q.push_back({b + 32'(4 * n), rf[k]});
                n++;
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic        hold_v = 1'b0;
    logic [31:0] hold_a;
    logic [31:0] hold_d;

    always @(negedge clk_i) begin
        if (rst_i) begin
            hold_v = 1'b0;
        end else begin
            if (done_o) done_total++;
            if (hold_v) begin
                chk("hold_req", {63'h0, mem_req_o}, 64'h1);
                chk("hold_bus", {mem_addr_o, mem_wdata_o}, {hold_a, hold_d});
            end
            if (mem_req_o) begin
                if (mem_ready_i) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'(exp_q.size()), 64'h1);
                    end else begin
                        chk("write", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
                    end
                    got_addr.push_back(mem_addr_o);
                    got_data.push_back(mem_wdata_o);
                end
            end else begin
                chk("idle_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
            end
            hold_v = mem_req_o && !mem_ready_i;
            hold_a = mem_addr_o;
            hold_d = mem_wdata_o;
        end
    end

    // ---------------- driver ----------------
    // Starts one operation (cycle 0 = acceptance cycle) and runs it to IDLE.
    // Write number hold_wr (0-based) sees mem_ready_i low for hold_n cycles.
    task automatic run_op(input logic [20:0] m, input logic [31:0] b,
                          input int hold_wr, input int hold_n, input bit busy_pulse,
                          output int done_cyc, output int stall_last,
                          output int done_cnt, output logic [4:0] rf1);
        int wr_seen;
        int left;
        bit fin;
        wr_seen    = 0;
        left       = hold_n;
        fin        = 1'b0;
        done_cyc   = -1;
        stall_last = -1;
        done_cnt   = 0;
        rf1        = 5'h1F;
        got_addr.delete();
        got_data.delete();
        build_model(m, b);

        start_i    = 1'b1;
        addrcode_i = m;
        base_i     = b;
        @(negedge clk_i);
        chk("start_stall", {63'h0, stall_o}, 64'h1);
        chk("start_not_busy", {63'h0, busy_o}, 64'h0);
        if (stall_o) stall_last = 0;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        addrcode_i = 21'($urandom);
        base_i     = $urandom;

        for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
            if (mem_req_o) begin
                if (wr_seen == hold_wr && left > 0) begin
                    mem_ready_i = 1'b0;
                    left--;
                end else begin
                    mem_ready_i = 1'b1;
                    wr_seen++;
                end
                if (busy_pulse && wr_seen == 1) begin
                    start_i    = 1'b1;
                    addrcode_i = 21'h1F0000;
                end
            end else begin
                mem_ready_i = 1'b1;
                start_i     = 1'b0;
            end
            @(negedge clk_i);
            if (cyc == 1) rf1 = rf_addr_o;
            if (stall_o) stall_last = cyc;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!busy_o) fin = 1'b1;
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        chk("op_finished", {63'h0, fin}, 64'h1);
        chk("writes_drained", 64'(exp_q.size()), 64'h0);
    endtask

    // ---------------- main sequence ----------------
    int         dc;
    int         sl;
    int         dn;
    logic [4:0] r1;
    int         done_before;

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'hC0DE0000 + 32'(k);
        rf[2] = 32'hDEADBEEF;

        // Reset state, with start_i high to confirm outputs stay low.
        rst_i       = 1'b1;
        start_i     = 1'b1;
        addrcode_i  = 21'h5;
        base_i      = 32'h40;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_outputs",
            {26'h0, stall_o, busy_o, done_o, mem_req_o, rf_addr_o, mem_addr_o},
            64'h0);
        chk("reset_wdata", {32'h0, mem_wdata_o}, 64'h0);
        start_i = 1'b0;
        rst_i   = 1'b0;
        @(posedge clk_i); #1;

        // Reset mid-write with memory not ready.
        done_before = done_total;
        start_i     = 1'b1;
        addrcode_i  = 21'h000003;
        base_i      = 32'h300;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        chk("midwrite_req", {63'h0, mem_req_o}, 64'h1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("abort_outputs", {58'h0, mem_req_o, busy_o, stall_o, done_o, 2'b00}, 64'h0);
        chk("abort_bus", {mem_addr_o, mem_wdata_o}, 64'h0);
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("abort_no_done", 64'(done_total), 64'(done_before));
        chk("abort_idle", {63'h0, busy_o}, 64'h0);

        // Single register r2.
        run_op(21'h000004, 32'h100, -1, 0, 1'b0, dc, sl, dn, r1);
        chk("single_rf_addr", 64'(r1), 64'd2);
        chk("single_done_cycle", 64'(dc), 64'd3);
        chk("single_done_count", 64'(dn), 64'd1);
        chk("single_stall_last", 64'(sl), 64'd2);
        chk("single_lit", {got_addr[0], got_data[0]}, {32'h100, 32'hDEADBEEF});

        // Sparse mask, second write backpressured 2 cycles.
        run_op(21'h100011, 32'h2000, 1, 2, 1'b0, dc, sl, dn, r1);
        chk("sparse_count", 64'(got_addr.size()), 64'd3);
        chk("sparse_w0", {got_addr[0], got_data[0]}, {32'h2000, 32'hC0DE0000});
        chk("sparse_w1", {got_addr[1], got_data[1]}, {32'h2004, 32'hC0DE0004});
        chk("sparse_w2", {got_addr[2], got_data[2]}, {32'h2008, 32'hC0DE0014});
        chk("sparse_done_cycle", 64'(dc), 64'd9);
        chk("sparse_done_count", 64'(dn), 64'd1);

        // Empty mask.
        run_op(21'h000000, 32'h700, -1, 0, 1'b0, dc, sl, dn, r1);
        chk("empty_writes", 64'(got_addr.size()), 64'd0);
        chk("empty_done_cycle", 64'(dc), 64'd1);
        chk("empty_stall_last", 64'(sl), 64'd0);

        // Full mask with address wrap.
        run_op(21'h1FFFFF, 32'hFFFFFFF8, -1, 0, 1'b0, dc, sl, dn, r1);
        chk("full_count", 64'(got_addr.size()), 64'd21);
        chk("full_a0", {32'h0, got_addr[0]}, {32'h0, 32'hFFFFFFF8});
        chk("full_a1", {32'h0, got_addr[1]}, {32'h0, 32'hFFFFFFFC});
        chk("full_a2", {32'h0, got_addr[2]}, 64'h0);
        chk("full_a20", {got_addr[20], got_data[20]}, {32'h48, 32'hC0DE0014});
        chk("full_done_cycle", 64'(dc), 64'd43);
        chk("full_stall_last", 64'(sl), 64'd42);

        // Start pulse while busy is ignored.
        run_op(21'h000022, 32'h500, -1, 0, 1'b1, dc, sl, dn, r1);
        chk("busy_count", 64'(got_addr.size()), 64'd2);
        chk("busy_w1", {got_addr[1], got_data[1]}, {32'h504, 32'hC0DE0005});
        chk("busy_done_cycle", 64'(dc), 64'd5);
        chk("busy_done_count", 64'(dn), 64'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("busy_back_idle", {63'h0, busy_o}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
